// File: rtl/gusn_link_pkg.sv
// Shared types and constants for the MNIST UART link blocks.
// Holds the frame-sender state encoding, the ASCII digit range and the default frame geometry.
package gusn_link_pkg;

  localparam int         IDX_W           = 10;
  localparam int         FRAME_BYTES_DEF = 784;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_NINE      = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RDWAIT,
    S_SEND,
    S_TXACK,
    S_TXDONE,
    S_RESP,
    S_FIN
  } sender_state_t;

  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
// A load takes priority over counting in the same cycle.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/img_frame_sender.sv
// Streams a frame from image memory through uart_tx, then decodes the single ASCII digit
// returned over uart_rx into result, flagging a bad character or a missing response.
module img_frame_sender
  import gusn_link_pkg::*;
#(
  parameter int FRAME_BYTES    = FRAME_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             err_timeout,
  output logic             err_char,
  output logic [IDX_W-1:0] mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic             tx_rq,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  output sender_state_t    state_dbg
);

  localparam int               TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_BYTES - 1);

  sender_state_t    state, next_state;
  logic [IDX_W-1:0] byte_idx;
  logic             rx_ready_q;
  logic             rx_edge;
  logic             timer_load, timer_en, timer_expired;
  logic             start_frame, latch_byte, advance;
  logic             set_result, set_err_char, set_err_timeout;

  // The reload leaves exactly TIMEOUT_CYCLES cycles in the waiting states before expiry.
  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (nRST),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (TIMER_RELOAD),
    .expired    (timer_expired)
  );

  assign rx_edge   = rx_ready & ~rx_ready_q;
  assign timer_en  = (state == S_TXACK) || (state == S_TXDONE) || (state == S_RESP);
  assign tx_rq     = (state == S_SEND);
  assign done      = (state == S_FIN);
  assign busy      = (state != S_IDLE);
  assign mem_addr  = byte_idx;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake with uart_tx: tx_rq is a single-cycle request, the byte is taken once tx_busy
  // rises and is on the wire until tx_busy falls; tx_data holds from SEND to the next RDWAIT.
  always_comb begin
    next_state      = state;
    timer_load      = 1'b0;
    start_frame     = 1'b0;
    latch_byte      = 1'b0;
    advance         = 1'b0;
    set_result      = 1'b0;
    set_err_char    = 1'b0;
    set_err_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          next_state  = S_FETCH;
        end
      end
      S_FETCH:  next_state = S_RDWAIT;
      S_RDWAIT: begin
        latch_byte = 1'b1;
        next_state = S_SEND;
      end
      S_SEND: begin
        timer_load = 1'b1;
        next_state = S_TXACK;
      end
      S_TXACK: begin
        if (tx_busy) begin
          next_state = S_TXDONE;
        end else if (timer_expired) begin
          set_err_timeout = 1'b1;
          next_state      = S_FIN;
        end
      end
      S_TXDONE: begin
        if (!tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            timer_load = 1'b1;
            next_state = S_RESP;
          end else begin
            advance    = 1'b1;
            next_state = S_FETCH;
          end
        end else if (timer_expired) begin
          set_err_timeout = 1'b1;
          next_state      = S_FIN;
        end
      end
      S_RESP: begin
        // A response arriving on the expiry cycle still counts as a valid answer.
        if (rx_edge) begin
          if (is_ascii_digit(rx_data)) begin
            set_result = 1'b1;
          end else begin
            set_err_char = 1'b1;
          end
          next_state = S_FIN;
        end else if (timer_expired) begin
          set_err_timeout = 1'b1;
          next_state      = S_FIN;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      byte_idx    <= '0;
      tx_data     <= '0;
      result      <= '0;
      err_timeout <= 1'b0;
      err_char    <= 1'b0;
      rx_ready_q  <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (start_frame) begin
        byte_idx    <= '0;
        result      <= '0;
        err_timeout <= 1'b0;
        err_char    <= 1'b0;
      end
      if (advance) begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
      if (latch_byte) begin
        tx_data <= mem_rdata;
      end
      // The low nibble of an ASCII digit is its numeric value.
      if (set_result) begin
        result <= rx_data[3:0];
      end
      if (set_err_char) begin
        err_char <= 1'b1;
      end
      if (set_err_timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_img_frame_sender.sv
// Bench for img_frame_sender: a full 784-byte instance and a single-byte instance, each with
// an address-pattern memory and a uart_tx model holding tx_busy for 20 cycles per byte.
module tb_img_frame_sender;
  import gusn_link_pkg::*;

  localparam int TO       = 1000;
  localparam int BUSY_LEN = 20;
  localparam int FB_A     = 784;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // instance a: full frame
  logic          nrst_a = 1'b0, start_a = 1'b0, tx_busy_a = 1'b0, rx_ready_a = 1'b0;
  logic [7:0]    rx_data_a = 8'h00, mem_rdata_a = 8'h00;
  logic          busy_a, done_a, err_timeout_a, err_char_a, tx_rq_a;
  logic [3:0]    result_a;
  logic [9:0]    mem_addr_a;
  logic [7:0]    tx_data_a;
  sender_state_t state_a;

  // instance b: one-byte frame
  logic          nrst_b = 1'b0, start_b = 1'b0, tx_busy_b = 1'b0, rx_ready_b = 1'b0;
  logic [7:0]    rx_data_b = 8'h00, mem_rdata_b = 8'h00;
  logic          busy_b, done_b, err_timeout_b, err_char_b, tx_rq_b;
  logic [3:0]    result_b;
  logic [9:0]    mem_addr_b;
  logic [7:0]    tx_data_b;
  sender_state_t state_b;

  img_frame_sender #(.FRAME_BYTES(FB_A), .TIMEOUT_CYCLES(TO)) u_dut_a (
    .clk(clk), .nRST(nrst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .result(result_a), .err_timeout(err_timeout_a), .err_char(err_char_a),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .tx_rq(tx_rq_a), .tx_data(tx_data_a),
    .tx_busy(tx_busy_a), .rx_ready(rx_ready_a), .rx_data(rx_data_a), .state_dbg(state_a)
  );

  img_frame_sender #(.FRAME_BYTES(1), .TIMEOUT_CYCLES(TO)) u_dut_b (
    .clk(clk), .nRST(nrst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .result(result_b), .err_timeout(err_timeout_b), .err_char(err_char_b),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .tx_rq(tx_rq_b), .tx_data(tx_data_b),
    .tx_busy(tx_busy_b), .rx_ready(rx_ready_b), .rx_data(rx_data_b), .state_dbg(state_b)
  );

  // image memories: data = address[7:0], one cycle latency
  always @(posedge clk) mem_rdata_a <= mem_addr_a[7:0];
  always @(posedge clk) mem_rdata_b <= mem_addr_b[7:0];

  // uart_tx models and output monitors
  logic       pend_a = 1'b0, pend_b = 1'b0, stuck_b = 1'b0;
  int         cnt_a = 0, cnt_b = 0, rq_cnt_a = 0, rq_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int         last_fall_a = -1, last_fall_b = -1, gap_a = -1;
  logic [7:0] obs_q_a[$];

  always @(negedge clk) begin
    if (pend_a) begin
      tx_busy_a = 1'b1; cnt_a = BUSY_LEN; pend_a = 1'b0;
    end else if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin tx_busy_a = 1'b0; last_fall_a = cyc; end
    end
    if (tx_rq_a) begin
      rq_cnt_a++;
      obs_q_a.push_back(tx_data_a);
      if (last_fall_a >= 0 && gap_a < 0) gap_a = cyc - last_fall_a;
      pend_a = 1'b1;
    end
    if (done_a) done_cnt_a++;
  end

  always @(negedge clk) begin
    if (pend_b) begin
      tx_busy_b = 1'b1; cnt_b = BUSY_LEN; pend_b = 1'b0;
    end else if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin tx_busy_b = 1'b0; last_fall_b = cyc; end
    end
    if (tx_rq_b) begin
      rq_cnt_b++;
      if (!stuck_b) pend_b = 1'b1;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, tx_rq_a, err_timeout_a, err_char_a, result_a, mem_addr_a, tx_data_a} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs_a got=%h exp=0", {busy_a, done_a, tx_rq_a, err_timeout_a, err_char_a, result_a, mem_addr_a, tx_data_a});
    end
    checks++;
    if (state_a !== S_IDLE) begin failures++; $display("FAIL reset_state_a got=%0d exp=%0d", state_a, S_IDLE); end
    checks++;
    if ({busy_b, done_b, tx_rq_b, err_timeout_b, err_char_b, result_b, mem_addr_b, tx_data_b} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs_b got=%h exp=0", {busy_b, done_b, tx_rq_b, err_timeout_b, err_char_b, result_b, mem_addr_b, tx_data_b});
    end
    checks++;
    if (state_b !== S_IDLE) begin failures++; $display("FAIL reset_state_b got=%0d exp=%0d", state_b, S_IDLE); end
  endtask

  task automatic test_normal_frame();
    int t0, lat, base, idx;
    logic [7:0] e, o;
    exp_q.delete(); obs_q_a.delete(); gap_a = -1; last_fall_a = -1;
    for (int i = 0; i < FB_A; i++) exp_q.push_back(8'(i));
    base = done_cnt_a;
    start_a = 1'b1; t0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_rise got=%b exp=1", busy_a); end
    // start is seen in cycle 0; tx_rq is high in cycle 3, the fourth cycle
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (tx_rq_a) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL first_rq_latency got=%0d exp=3", lat); end
    for (int i = 0; i < 40000 && rq_cnt_a < FB_A; i++) @(negedge clk);
    checks++;
    if (rq_cnt_a != FB_A) begin failures++; $display("FAIL frame_rq_count got=%0d exp=%0d", rq_cnt_a, FB_A); end
    for (int i = 0; i < 5 && !tx_busy_a; i++) @(negedge clk);
    for (int i = 0; i < 40 && tx_busy_a; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rx_data_a = 8'h37; rx_ready_a = 1'b1;
    for (int i = 0; i < 20 && !done_a; i++) @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin failures++; $display("FAIL normal_done got=%b exp=1", done_a); end
    checks++;
    if (result_a !== 4'd7) begin failures++; $display("FAIL normal_result got=%0d exp=7", result_a); end
    repeat (3) @(negedge clk);
    rx_ready_a = 1'b0;
    checks++;
    if (done_cnt_a - base != 1) begin failures++; $display("FAIL normal_done_pulses got=%0d exp=1", done_cnt_a - base); end
    checks++;
    if ({err_timeout_a, err_char_a, busy_a} !== 3'b000) begin
      failures++; $display("FAIL normal_flags got=%b exp=000", {err_timeout_a, err_char_a, busy_a});
    end
    checks++;
    if (gap_a != 3) begin failures++; $display("FAIL inter_byte_gap got=%0d exp=3", gap_a); end
    checks++;
    if (obs_q_a.size() != exp_q.size()) begin
      failures++; $display("FAIL sb_size got=%0d exp=%0d", obs_q_a.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && obs_q_a.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q_a.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL sb_byte idx=%0d got=%h exp=%h", idx, o, e); end
      idx++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, hold;
    logic [7:0] e, o;
    base = rq_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 12000 && rq_cnt_a - base < 300; i++) @(negedge clk);
    nrst_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, tx_rq_a, err_timeout_a, err_char_a, result_a, mem_addr_a, tx_data_a} !== 27'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {busy_a, done_a, tx_rq_a, err_timeout_a, err_char_a, result_a, mem_addr_a, tx_data_a});
    end
    checks++;
    if (state_a !== S_IDLE) begin failures++; $display("FAIL midreset_state got=%0d exp=%0d", state_a, S_IDLE); end
    hold = rq_cnt_a;
    repeat (5) @(negedge clk);
    checks++;
    if (rq_cnt_a != hold) begin failures++; $display("FAIL midreset_no_rq got=%0d exp=%0d", rq_cnt_a, hold); end
    nrst_a = 1'b1;
    for (int i = 0; i < 40 && (tx_busy_a || pend_a); i++) @(negedge clk);
    obs_q_a.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 200 && obs_q_a.size() < 3; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      o = (obs_q_a.size() > 0) ? obs_q_a.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin failures++; $display("FAIL restart_byte idx=%0d got=%h exp=%h", i, o, e); end
    end
    nrst_a = 1'b0;
    @(negedge clk);
    nrst_a = 1'b1;
    for (int i = 0; i < 40 && (tx_busy_a || pend_a); i++) @(negedge clk);
    obs_q_a.delete();
  endtask

  task automatic test_boundary();
    int base;
    base = done_cnt_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 10 && !tx_rq_b; i++) @(negedge clk);
    @(negedge clk);  // TXACK cycle: stale echo pulse
    rx_data_b = 8'h32; rx_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready_b = 1'b0;
    for (int i = 0; i < 40 && (tx_busy_b || pend_b); i++) @(negedge clk);
    checks++;
    if (done_cnt_b != base) begin failures++; $display("FAIL boundary_early_done got=%0d exp=%0d", done_cnt_b, base); end
    repeat (2) @(negedge clk);
    rx_data_b = 8'h35; rx_ready_b = 1'b1;
    for (int i = 0; i < 20 && !done_b; i++) @(negedge clk);
    checks++;
    if (done_b !== 1'b1) begin failures++; $display("FAIL boundary_done got=%b exp=1", done_b); end
    checks++;
    if ({result_b, err_char_b, err_timeout_b} !== {4'd5, 2'b00}) begin
      failures++; $display("FAIL boundary_result got=%0d/%b%b exp=5/00", result_b, err_char_b, err_timeout_b);
    end
    repeat (3) @(negedge clk);
    rx_ready_b = 1'b0;
  endtask

  task automatic test_bad_response();
    int base;
    base = done_cnt_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 10 && !tx_rq_b; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 40 && (tx_busy_b || pend_b); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rx_data_b = 8'h41; rx_ready_b = 1'b1;
    for (int i = 0; i < 20 && !done_b; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rx_ready_b = 1'b0;
    checks++;
    if (done_cnt_b - base != 1) begin failures++; $display("FAIL bad_done_pulses got=%0d exp=1", done_cnt_b - base); end
    checks++;
    if ({result_b, err_char_b, err_timeout_b} !== {4'd0, 2'b10}) begin
      failures++; $display("FAIL bad_char got=%0d/%b%b exp=0/10", result_b, err_char_b, err_timeout_b);
    end
  endtask

  task automatic test_no_response();
    int t_err;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 10 && !tx_rq_b; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    // level already high when RESP is entered: must not count as a response
    rx_data_b = 8'h33; rx_ready_b = 1'b1;
    for (int i = 0; i < 40 && tx_busy_b; i++) @(negedge clk);
    t_err = -1;
    for (int i = 0; i < 1100; i++) begin
      if (err_timeout_b) begin t_err = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (t_err < 0 || t_err - last_fall_b < TO - 2 || t_err - last_fall_b > TO + 2) begin
      failures++; $display("FAIL timeout_latency got=%0d exp=%0d+-2", t_err - last_fall_b, TO);
    end
    checks++;
    if ({done_b, result_b, err_char_b} !== {1'b1, 4'd0, 1'b0}) begin
      failures++; $display("FAIL timeout_outputs got=%b/%0d/%b exp=1/0/0", done_b, result_b, err_char_b);
    end
    repeat (2) @(negedge clk);
    rx_ready_b = 1'b0;
  endtask

  task automatic test_stuck_tx();
    int base;
    stuck_b = 1'b1;
    base = rq_cnt_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 1100 && !done_b; i++) @(negedge clk);
    checks++;
    if ({done_b, err_timeout_b} !== 2'b11) begin
      failures++; $display("FAIL stuck_timeout got=%b%b exp=11", done_b, err_timeout_b);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rq_cnt_b - base != 1) begin failures++; $display("FAIL stuck_rq_count got=%0d exp=1", rq_cnt_b - base); end
    stuck_b = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal_frame();
    test_reset_mid_frame();
    test_boundary();
    test_bad_response();
    test_no_response();
    test_stuck_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_frame_sender.md
# img_frame_sender

Drives the MNIST classifier's UART link from the other end. On `start` it reads a 784-byte frame from a local image memory and transmits it byte by byte through a `uart_tx` instance. It then waits for the single ASCII digit that the classifier returns and decodes it into `result`. It sits in self-test and board-to-board builds beside `uart_tx`/`uart_rx` and `uart_baud`.

## Interface
- `FRAME_BYTES`, 784: bytes sent per frame.
- `TIMEOUT_CYCLES`, 100_000_000: clk cycles allowed for the response after the last byte; also bounds each per-byte tx wait.
- `clk` in 1: system clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `start` in 1: level; sampled only in IDLE.
- `busy` out 1: high from start acceptance until `done`.
- `done` out 1: one-cycle pulse at frame completion (success or error).
- `result` out 4: decoded digit 0–9; held until the next accepted `start`.
- `err_timeout` out 1: sticky per frame; set with `done`, cleared on the next `start`.
- `err_char` out 1: sticky per frame; response was not 0x30–0x39.
- `mem_addr` out 10: image memory read address.
- `mem_rdata` in 8: memory data, valid 1 cycle after `mem_addr`.
- `tx_rq` out 1: one-cycle request to `uart_tx`.
- `tx_data` out 8: byte for `uart_tx`; stable while tx is busy.
- `tx_busy` in 1: from `uart_tx`.
- `rx_ready` in 1: level ready flag from `uart_rx`.
- `rx_data` in 8: byte from `uart_rx`.

## Operation
FSM states and transitions:
- **IDLE:** when `start`=1, clear `err_*` and `result`, set `byte_idx`=0, go to FETCH.
- **FETCH:** drive `mem_addr`=`byte_idx`, go to RDWAIT.
- **RDWAIT:** latch `mem_rdata` into `tx_data`, go to SEND.
- **SEND:** `tx_rq`=1 for exactly this cycle, go to TXACK.
- **TXACK:** wait for `tx_busy`=1. Then go to TXDONE.
- **TXDONE:** wait for `tx_busy`=0. Then:
  - if `byte_idx`==FRAME_BYTES-1, go to RESP;
  - else increment `byte_idx` and go to FETCH.
- **RESP:** wait for a rising edge of `rx_ready` (registered copy compared with current value).
  - On the edge, if `rx_data` is in 0x30–0x39: `result`=`rx_data`-0x30 (low 4 bits).
  - Otherwise set `err_char`; `result` stays 0.
  - Either way, go to FIN.
- **FIN:** `done`=1 for one cycle, go to IDLE.

Timeout:
- Timer reloads on entry to TXACK and RESP and counts down in TXACK, TXDONE and RESP.
- On expiry, set `err_timeout` and go to FIN.

Other rules:
- `rx_ready` edges outside RESP are ignored; a stale echo during transmission never produces a result.
- The `rx_ready` edge detector updates in every state, so a level already high on entry to RESP is not an edge.
- `byte_idx` is 10 bits and never wraps beyond FRAME_BYTES-1.

## Timing
- Reset values: state IDLE; `busy`, `done`, `tx_rq`, `err_*` all 0; `result` 0; `mem_addr` 0; `tx_data` 0.
- `start` → first `tx_rq`: 4 cycles (IDLE→FETCH→RDWAIT→SEND).
- Between bytes: 3 cycles of overhead after `tx_busy` falls, on top of the UART frame time.
- `busy` rises the cycle after `start` is seen and falls the cycle after `done`.
- `start` held high across FIN starts a new frame from IDLE on the next cycle. It is not an error.
- `nRST` asserted mid-frame:
  - immediate return to reset values;
  - no further `tx_rq`;
  - a byte already in `uart_tx` finishes on its own.
- Simultaneous timeout expiry and `rx_ready` edge in RESP: the valid byte wins and no timeout is flagged.

## Structure
- `gusn_link_pkg` holds:
  - the state enum `sender_state_t`;
  - `ASCII_ZERO`=8'h30;
  - the default `FRAME_BYTES`=784;
  - the byte-index width 10.
- One sub-module, `cycle_timer`: loadable down-counter with `load`, `en`, `expired`.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - It is reused by later link blocks.

## Test plan
- **Normal frame:** memory = address[7:0]; `uart_tx` model with `tx_busy` high 20 cycles; responder returns 0x37. Require: 784 `tx_rq` pulses carrying bytes 0x00..0xFF repeating, in order; then `result`=7, `done` pulsed once, `err_*`=0.
- **Bad response:** 0x41 returned. Require: `err_char`=1, `result`=0, `done` pulse.
- **No response:** TIMEOUT_CYCLES=1000. Require: `err_timeout` within 1000±2 cycles after the last `tx_busy` fall.
- **Stuck `tx_busy`:** `tx_busy` held low after `tx_rq`. Require: timeout, `done`, at most 1 `tx_rq` issued.
- **Reset mid-frame:** `nRST` low at byte 300. Require: all outputs at reset values next cycle; a fresh `start` sends from address 0.
- **Boundary:** FRAME_BYTES=1 with an `rx_ready` pulse injected during TXACK. Require: the pulse is ignored; only the response in RESP sets `result`.
